// File: rtl/byte_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : byte_deserializer
// Brief   : Serial bit stream to byte assembler feeding a show-ahead FIFO.
// Revision: 1.0
// ============================================================================
package A;
  localparam int WIDTH = 8;
  typedef logic [WIDTH-1:0] byte_t;
endpackage

module byte_deserializer
  import A::*;
#(
  parameter int LSB_FIRST = 1,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_valid,
  input  logic                       bit_in,
  input  logic                       frame_start,
  output logic                       byte_valid,
  input  logic                       byte_ready,
  output byte_t                      byte_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       misalign
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  byte_t              shreg_q, shreg_d;
  byte_t              mem_q [DEPTH];
  byte_t              mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               misalign_q, misalign_d;

  logic               capture;
  logic [2:0]         cap_idx;
  logic [2:0]         bit_pos;
  byte_t              assembled;
  logic               push_req;
  logic               push_ok;
  logic               pop;

  // Bit assembly: frame_start forces the incoming bit to be bit 0 of a new byte.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    misalign_d = misalign_q;
    push_req   = 1'b0;
    capture    = 1'b0;
    cap_idx    = cnt_q;
    if (bit_valid) begin
      if (frame_start) begin
        capture = 1'b1;
        cap_idx = 3'd0;
        if (state_q == SHIFT && cnt_q != 3'd0) begin
          misalign_d = 1'b1;
        end
      end else if (state_q == SHIFT) begin
        capture = 1'b1;
      end
    end
    bit_pos   = (LSB_FIRST != 0) ? cap_idx : 3'd7 - cap_idx;
    assembled = (cap_idx == 3'd0) ? '0 : shreg_q;
    assembled[bit_pos] = bit_in;
    if (capture) begin
      state_d  = SHIFT;
      cnt_d    = cap_idx + 3'd1;
      shreg_d  = assembled;
      push_req = (cap_idx == 3'd7);
    end
  end

  assign byte_valid = (level_q != '0);
  assign pop        = byte_valid && byte_ready;
  // A full FIFO can still take a byte when the head leaves in the same cycle.
  assign push_ok    = push_req && ((level_q != FULL_LEVEL) || pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = assembled;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else if (push_req) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shreg_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign byte_data = byte_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign misalign  = misalign_q;

endmodule

`default_nettype wire

// File: doc/byte_deserializer.md
BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

Interface
REQ-001 The module SHALL import package A in its module header and type all byte-wide data ports as A::byte_t (8 bits, WIDTH = 8).
REQ-002 Parameter: LSB_FIRST, default 1, meaning 1 = first received bit lands in data[0], 0 = first bit lands in data[7].
REQ-003 Parameter: DEPTH, default 4, meaning output FIFO entries; legal values are powers of two, 2..16.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 bit_valid  input  1  bit_in is valid this cycle.
REQ-007 bit_in  input  1  serial data bit.
REQ-008 frame_start  input  1  qualified by bit_valid; marks bit_in as bit 0 of a new byte.
REQ-009 byte_valid  output  1  FIFO head holds a byte.
REQ-010 byte_ready  input  1  consumer accepts the head byte when byte_valid is also high.
REQ-011 byte_data  output  byte_t  FIFO head byte, show-ahead.
REQ-012 level  output  $clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 overflow  output  1  sticky flag: a completed byte was dropped.
REQ-014 misalign  output  1  sticky flag: a partial byte was discarded by frame_start.

Function
REQ-015 FSM states SHALL be IDLE and SHIFT, with a 3-bit bit counter cnt.
- IDLE: bit_valid without frame_start is ignored.
- IDLE: bit_valid with frame_start captures bit 0, sets cnt=1, and moves to SHIFT.
REQ-016 In SHIFT, each bit_valid SHALL place bit_in at position cnt (LSB_FIRST=1) or 7-cnt (LSB_FIRST=0) and increment cnt.
REQ-017 When the 8th bit is captured (cnt==7), the assembled byte SHALL be pushed, cnt SHALL wrap to 0, and the FSM SHALL stay in SHIFT.
- Back-to-back bytes therefore need no further frame_start.
REQ-018 frame_start with bit_valid in SHIFT while cnt!=0 SHALL discard the partial byte, set misalign, treat bit_in as bit 0, and set cnt=1.
REQ-019 frame_start with bit_valid in SHIFT while cnt==0 SHALL be a normal realignment with no flag.
REQ-020 bit_valid low SHALL hold cnt and all partial data unchanged, with no timeout.
REQ-021 Latency: a byte completed in cycle N SHALL appear on byte_data with byte_valid high in cycle N+1 if the FIFO was empty.
REQ-022 A pop SHALL occur when byte_valid and byte_ready are both high.
- The next entry (or byte_valid low) SHALL be visible in the following cycle.
REQ-023 A push SHALL be accepted if level<DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte SHALL be dropped, overflow set, and FIFO contents unchanged.
REQ-024 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-025 FIFO read and write pointers SHALL wrap modulo DEPTH.
- level SHALL never exceed DEPTH or underflow.
REQ-026 byte_data SHALL be stable while byte_valid is high and byte_ready is low.
REQ-027 overflow and misalign SHALL remain set until reset.

Reset
REQ-028 While rst is high at a clock edge, the following SHALL apply on the next cycle:
- FSM=IDLE and cnt=0, partial byte discarded;
- FIFO emptied: level=0, byte_valid=0, byte_data=8'h00;
- overflow=0 and misalign=0.
REQ-029 Reset asserted mid-byte or with a full FIFO SHALL discard all data.
- Bits arriving in the reset cycle SHALL be ignored.
- The first byte after reset SHALL require frame_start.

Verification
REQ-030 LSB_FIRST=1: send bits 1,0,1,0,0,1,0,1 with frame_start on the first bit and byte_ready=1.
- Expect byte_data=8'hA5 with byte_valid high for exactly 1 cycle, 1 cycle after the last bit.
REQ-031 LSB_FIRST=0: send the same bit stream.
- Expect byte_data=8'hA5.
REQ-032 byte_ready=0, DEPTH=4: stream 5 bytes 8'h01..8'h05.
- Expect level=4 and overflow=1.
- Then raising byte_ready pops 01,02,03,04 in order, and level returns to 0.
REQ-033 FIFO full with byte_ready=1: complete a byte in the same cycle as a pop.
- Expect the push accepted, level stays 4, and overflow stays 0.
REQ-034 After 3 bits of a byte, assert frame_start with bit_valid, then 7 more bits of 8'h3C.
- Expect misalign=1, the partial byte discarded, and byte_data=8'h3C.
REQ-035 Assert rst for 1 cycle mid-byte with 2 bytes queued.
- Expect level=0, byte_valid=0, and both flags clear next cycle.
- Bits without frame_start afterwards produce no output.
